// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK compress/decompress page managers.
package hacd_pkg;

  localparam int HAWK_LINE_BYTES = 64;
  localparam int HAWK_PAGE_LINES = 64;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_mngr_state_t;

  typedef struct packed {
    rd_mngr_state_t state;
    logic [6:0]     ar_cnt;
    logic [6:0]     r_cnt;
  } debug_pgrd_cmpdcmp_mngr;

endpackage

// File: rtl/hawk_cmpdcmp_rd_mngr.sv
// Page read manager: issues one single-beat AXI read per cache line, bounds
// outstanding reads and forwards every returned line into the write FIFO.
module hawk_cmpdcmp_rd_mngr
  import hacd_pkg::*;
#(
  parameter int LINE_BYTES      = HAWK_LINE_BYTES,
  parameter int MAX_LINES       = HAWK_PAGE_LINES,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = LINE_BYTES * 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trigger_i,
  input  logic [ADDR_W-1:0]      src_addr_i,
  input  logic [6:0]             nlines_i,
  output logic [ADDR_W-1:0]      araddr_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  input  logic [DATA_W-1:0]      rdata_i,
  input  logic [1:0]             rresp_i,
  input  logic                   rvalid_i,
  output logic                   rready_o,
  output logic [DATA_W-1:0]      fifo_wdata_o,
  output logic                   fifo_push_o,
  input  logic                   fifo_full_i,
  output logic                   rd_busy_o,
  output logic                   rd_done_o,
  output logic                   rd_err_o,
  output debug_pgrd_cmpdcmp_mngr debug_rd_mngr_o
);

  localparam int               OFF_W   = $clog2(LINE_BYTES);
  localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [6:0]       MAX_N   = 7'(MAX_LINES);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  rd_mngr_state_t    state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        n_q, n_d;
  logic [6:0]        ar_cnt_q, ar_cnt_d;
  logic [6:0]        r_cnt_q, r_cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              err_q, err_d;
  logic              ar_hs, r_hs;
  logic [6:0]        n_clamp;
  logic              unused_line_offset;

  assign n_clamp            = (nlines_i > MAX_N) ? MAX_N : nlines_i;
  assign unused_line_offset = ^src_addr_i[OFF_W-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    base_d       = base_q;
    n_d          = n_q;
    ar_cnt_d     = ar_cnt_q;
    r_cnt_d      = r_cnt_q;
    out_d        = out_q;
    err_d        = err_q;
    arvalid_o    = 1'b0;
    araddr_o     = '0;
    rready_o     = 1'b0;
    fifo_push_o  = 1'b0;
    fifo_wdata_o = '0;
    rd_done_o    = 1'b0;
    rd_err_o     = 1'b0;

    // AR depends only on registered state, so it stays stable until accepted.
    if (state_q == RD_ISSUE && ar_cnt_q < n_q && out_q < OUT_MAX) begin
      arvalid_o = 1'b1;
      araddr_o  = base_q + (ADDR_W'(ar_cnt_q) << OFF_W);
    end
    ar_hs = arvalid_o && arready_i;

    rready_o = (state_q == RD_ISSUE || state_q == RD_DRAIN) && !fifo_full_i;
    r_hs     = rready_o && rvalid_i;

    if (r_hs) begin
      fifo_push_o  = 1'b1;
      fifo_wdata_o = rdata_i;
      r_cnt_d      = r_cnt_q + 7'd1;
      err_d        = err_q | (rresp_i != 2'b00);
    end
    if (ar_hs) ar_cnt_d = ar_cnt_q + 7'd1;

    if (ar_hs && !r_hs)                     out_d = out_q + 1'b1;
    else if (r_hs && !ar_hs && out_q != '0) out_d = out_q - 1'b1;

    case (state_q)
      RD_IDLE: begin
        if (trigger_i) begin
          base_d   = {src_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          n_d      = n_clamp;
          ar_cnt_d = '0;
          r_cnt_d  = '0;
          out_d    = '0;
          err_d    = 1'b0;
          state_d  = (n_clamp == '0) ? RD_DONE : RD_ISSUE;
        end
      end
      RD_ISSUE: if (ar_hs && ar_cnt_d == n_q) state_d = RD_DRAIN;
      RD_DRAIN: if (r_hs && r_cnt_d == n_q)   state_d = RD_DONE;
      RD_DONE: begin
        rd_done_o = 1'b1;
        rd_err_o  = err_q;
        state_d   = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      state_q  <= RD_IDLE;
      base_q   <= '0;
      n_q      <= '0;
      ar_cnt_q <= '0;
      r_cnt_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      ar_cnt_q <= ar_cnt_d;
      r_cnt_q  <= r_cnt_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign rd_busy_o       = (state_q != RD_IDLE);
  assign debug_rd_mngr_o = '{state: state_q, ar_cnt: ar_cnt_q, r_cnt: r_cnt_q};

endmodule

// File: tb/tb_hawk_cmpdcmp_rd_mngr.sv
// Self-checking bench: AXI slave model with configurable latency/backpressure and a line-level scoreboard.
module tb_hawk_cmpdcmp_rd_mngr;
  import hacd_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   trigger_i = 1'b0;
  logic [63:0]            src_addr_i = '0;
  logic [6:0]             nlines_i = '0;
  logic [63:0]            araddr_o;
  logic                   arvalid_o;
  logic                   arready_i = 1'b0;
  logic [511:0]           rdata_i = '0;
  logic [1:0]             rresp_i = '0;
  logic                   rvalid_i = 1'b0;
  logic                   rready_o;
  logic [511:0]           fifo_wdata_o;
  logic                   fifo_push_o;
  logic                   fifo_full_i = 1'b0;
  logic                   rd_busy_o, rd_done_o, rd_err_o;
  debug_pgrd_cmpdcmp_mngr dbg;

  hawk_cmpdcmp_rd_mngr dut (
    .clk_i(clk_i), .rst_i(rst_i), .trigger_i(trigger_i), .src_addr_i(src_addr_i),
    .nlines_i(nlines_i), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_push_o(fifo_push_o), .fifo_full_i(fifo_full_i),
    .rd_busy_o(rd_busy_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
    .debug_rd_mngr_o(dbg)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [63:0] addr; int due; } rd_t;
  rd_t         rq[$];
  logic [63:0] ar_log[$];
  logic [511:0] push_log[$];

  int          cyc = 0;
  int          r_delay = 0;
  bit          ar_rand = 0, r_stall = 0, full_rand = 0;
  int          full_start = -100;
  logic [63:0] err_addr = '1;
  logic [63:0] salt = '0;
  int          exp_n = 0;

  int mon_out = 0, max_out = 0;
  int stab_viol = 0, full_viol = 0, push_viol = 0, gate_viol = 0, resume_viol = 0, err_viol = 0;
  int done_cnt = 0, done_cyc = 0, first_ar_cyc = -1, last_r_cyc = 0;
  bit done_err = 0, done_busy = 0;
  bit prev_arv = 0, prev_ar_hs = 0, prev_unblock = 0, r_hs_last = 0;
  logic [63:0] prev_addr = '0;

  function automatic logic [511:0] line_data(input logic [63:0] a);
    return {8{a ^ salt}};
  endfunction

  // Monitor: sampled mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk_i) begin
    bit ar_hs, r_hs;
    ar_hs = arvalid_o && arready_i;
    r_hs  = rready_o && rvalid_i;
    if (rst_i) begin
      rq.delete();
      mon_out = 0; prev_arv = 0; prev_unblock = 0; r_hs_last = 0;
    end else begin
      if (prev_arv && !prev_ar_hs && (!arvalid_o || araddr_o !== prev_addr)) stab_viol++;
      if (prev_unblock && !arvalid_o) resume_viol++;
      if (arvalid_o && mon_out >= 4) gate_viol++;
      if (rready_o && fifo_full_i) full_viol++;
      if (fifo_push_o !== r_hs) push_viol++;
      if (rd_err_o && !rd_done_o) err_viol++;
      if (arvalid_o && first_ar_cyc < 0) first_ar_cyc = cyc;
      if (ar_hs) begin
        ar_log.push_back(araddr_o);
        rq.push_back('{araddr_o, cyc + r_delay});
      end
      if (r_hs) begin
        push_log.push_back(fifo_wdata_o);
        last_r_cyc = cyc;
        if (rq.size() > 0) void'(rq.pop_front());
      end
      prev_unblock = r_hs && !ar_hs && mon_out == 4 && ar_log.size() < exp_n;
      mon_out = mon_out + int'(ar_hs) - int'(r_hs);
      if (mon_out > max_out) max_out = mon_out;
      if (rd_done_o) begin
        done_cnt++; done_cyc = cyc; done_err = rd_err_o; done_busy = rd_busy_o;
      end
      prev_arv = arvalid_o; prev_ar_hs = ar_hs; prev_addr = araddr_o;
      r_hs_last = r_hs;
    end
  end

  // AXI slave and FIFO model: inputs change 1 ns after the rising edge.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    arready_i   = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_full_i = (cyc >= full_start && cyc < full_start + 20) ||
                  (full_rand && ($urandom_range(0, 3) == 0));
    if (!(rvalid_i && !r_hs_last && rq.size() > 0)) begin
      if (rq.size() > 0 && rq[0].due <= cyc && (!r_stall || $urandom_range(0, 2) != 0)) begin
        rvalid_i = 1'b1;
        rdata_i  = line_data(rq[0].addr);
        rresp_i  = (rq[0].addr == err_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rresp_i  = 2'b00;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, " arvalid"}, 64'(arvalid_o), 64'd0);
    check({tag, " araddr"}, araddr_o, 64'd0);
    check({tag, " rready"}, 64'(rready_o), 64'd0);
    check({tag, " push"}, 64'(fifo_push_o), 64'd0);
    check({tag, " wdata nonzero"}, 64'(fifo_wdata_o != '0), 64'd0);
    check({tag, " busy"}, 64'(rd_busy_o), 64'd0);
    check({tag, " done"}, 64'(rd_done_o), 64'd0);
    check({tag, " err"}, 64'(rd_err_o), 64'd0);
    check({tag, " debug"}, 64'(dbg), 64'd0);
  endtask

  task automatic run_req(input string tag, input logic [63:0] addr, input logic [6:0] nl,
                         input bit retrig);
    logic [63:0] base;
    int n, trig_cyc, addr_bad, data_bad;
    bit got, exp_err;
    base = {addr[63:6], 6'b0};
    n = (nl > 7'd64) ? 64 : int'(nl);
    exp_err = 0;
    for (int k = 0; k < n; k++) if (base + 64'(k) * 64'd64 == err_addr) exp_err = 1;
    exp_n = n;
    ar_log.delete(); push_log.delete();
    done_cnt = 0; first_ar_cyc = -1; max_out = 0;
    salt = {$urandom, $urandom};
    @(posedge clk_i); #1;
    trigger_i = 1'b1; src_addr_i = addr; nlines_i = nl; trig_cyc = cyc;
    @(posedge clk_i); #1;
    trigger_i = 1'b0; src_addr_i = {$urandom, $urandom}; nlines_i = 7'($urandom);
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk_i);
      if (done_cnt > 0) got = 1;
      else if (retrig && i == 3) begin
        @(posedge clk_i); #1;
        trigger_i = 1'b1; src_addr_i = 64'hdead_0000; nlines_i = 7'd3;
        @(posedge clk_i); #1;
        trigger_i = 1'b0;
      end
    end
    check({tag, " done seen"}, 64'(got), 64'd1);
    check({tag, " ar count"}, 64'(ar_log.size()), 64'(n));
    check({tag, " push count"}, 64'(push_log.size()), 64'(n));
    addr_bad = 0;
    data_bad = 0;
    for (int i = 0; i < ar_log.size(); i++)
      if (ar_log[i] !== base + 64'(i) * 64'd64) addr_bad++;
    for (int i = 0; i < push_log.size(); i++)
      if (push_log[i] !== line_data(base + 64'(i) * 64'd64)) data_bad++;
    check({tag, " ar addr mismatches"}, 64'(addr_bad), 64'd0);
    check({tag, " push data mismatches"}, 64'(data_bad), 64'd0);
    check({tag, " rd_err at done"}, 64'(done_err), 64'(exp_err));
    check({tag, " busy during done"}, 64'(done_busy), 64'd1);
    check({tag, " outstanding bound"}, 64'(max_out <= 4), 64'd1);
    if (n > 0) begin
      check({tag, " first ar latency"}, 64'(first_ar_cyc - trig_cyc), 64'd1);
      check({tag, " done after last R"}, 64'(done_cyc - last_r_cyc), 64'd1);
    end else begin
      check({tag, " zero done latency"},
            64'((done_cyc - trig_cyc) >= 1 && (done_cyc - trig_cyc) <= 2), 64'd1);
    end
  endtask

  initial begin
    bit got;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_idle("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run_req("full", 64'h8000_1000, 7'd64, 0);
    if (ar_log.size() == 64) check("full last addr", ar_log[63], 64'h8000_1fc0);

    r_delay = 10;
    run_req("outst", 64'h4000, 7'd16, 0);
    check("outst reached limit", 64'(max_out), 64'd4);

    r_delay = 2;
    full_start = cyc + 15;
    run_req("bp", 64'h1_0000, 7'd64, 0);
    full_start = -100;

    r_delay = 0;
    run_req("zero", 64'h5000, 7'd0, 0);
    run_req("clamp", 64'h6000, 7'd100, 0);

    err_addr = 64'h7000 + 64'd5 * 64'd64;
    run_req("err", 64'h7000, 7'd8, 0);
    err_addr = '1;

    r_delay = 10;
    exp_n = 16;
    ar_log.delete(); push_log.delete();
    @(posedge clk_i); #1;
    trigger_i = 1'b1; src_addr_i = 64'h9000; nlines_i = 7'd16;
    @(posedge clk_i); #1;
    trigger_i = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (ar_log.size() >= 3) got = 1;
    end
    check("rst wait 3 ARs", 64'(got), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_idle("mid rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    r_delay = 1;
    run_req("post rst", 64'hA000, 7'd12, 0);

    r_delay = 3;
    run_req("misalign", 64'h1234_5677, 7'd8, 1);
    if (ar_log.size() > 0) check("misalign first addr", ar_log[0], 64'h1234_5640);

    r_delay = 0;
    run_req("wrap", 64'hffff_ffff_ffff_ff80, 7'd4, 0);

    ar_rand = 1; r_stall = 1; full_rand = 1;
    for (int t = 0; t < 6; t++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      r_delay = int'($urandom_range(0, 5));
      err_addr = ($urandom_range(0, 1) == 1) ? ({a[63:6], 6'b0} + 64'($urandom_range(0, 70)) * 64'd64)
                                             : '1;
      run_req($sformatf("rand%0d", t), a, 7'($urandom_range(0, 100)), 0);
    end
    ar_rand = 0; r_stall = 0; full_rand = 0;

    repeat (5) @(negedge clk_i);
    check("single done pulse", 64'(done_cnt), 64'd1);
    check("idle after runs", 64'(rd_busy_o), 64'd0);
    check("ar stability", 64'(stab_viol), 64'd0);
    check("rready while full", 64'(full_viol), 64'd0);
    check("push vs R handshake", 64'(push_viol), 64'd0);
    check("arvalid at limit", 64'(gate_viol), 64'd0);
    check("ar resume after R", 64'(resume_viol), 64'd0);
    check("err without done", 64'(err_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
